pixel_bist_ctrl: RTL and testbench
==================================

// Module: pixel_bist_ctrl
// PURPOSE
//  Parametrised self-test controller for the gray/sobel pixel pipeline; successor to separate LFSR + signature analyzer.
//  Generates a seeded pseudo-random pixel stream, compacts pipeline outputs in a MISR and compares against a golden value.
//  Sits between the SPI config registers and top_gray_sobel; reports busy/done/pass/timeout to the top-level status bits.
// PARAMETERS
//  DATA_W    24         pattern/signature width (bits)
//  PX_OUT_W  8          pipeline output pixel width, zero-extended into MISR (PX_OUT_W <= DATA_W)
//  CNT_W     16         pattern counter width; max patterns 2**CNT_W-1
//  POLY      24'hE10000 Galois feedback mask, shared by LFSR and MISR
//  DRAIN_TMO 64         idle cycles allowed in DRAIN before timeout
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         asynchronous, active-low reset
//  start_i      in   1         1-cycle start pulse; honoured in IDLE/DONE only
//  abort_i      in   1         return to IDLE from any state
//  cfg_seed_i   in   DATA_W    LFSR seed, sampled at start
//  cfg_count_i  in   CNT_W     number of patterns, sampled at start
//  golden_i     in   DATA_W    expected signature, sampled in CHECK
//  pat_data_o   out  DATA_W    pattern to pipeline
//  pat_vld_o    out  1         pattern valid
//  dut_data_i   in   PX_OUT_W  pipeline output pixel
//  dut_vld_i    in   1         pipeline output valid
//  busy_o       out  1         FSM not in IDLE/DONE
//  done_o       out  1         sticky result-valid; cleared by next start/abort
//  pass_o       out  1         signature==golden; valid while done_o
//  timeout_o    out  1         DRAIN timed out; valid while done_o
//  signature_o  out  DATA_W    live MISR value
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, LFSR=1, MISR=0, counters 0.
//  Step fn f(s) = (s>>1) ^ (s[0] ? POLY : 0).
//  States: IDLE -> LOAD -> GEN -> DRAIN -> CHECK -> DONE.
//  IDLE/DONE + start_i: LOAD next cycle; done/pass/timeout cleared; MISR cleared.
//  LOAD (1 cyc): LFSR<=seed (seed==0 replaced by 1); tx_cnt<=count; rx_cnt<=0. count==0 -> CHECK directly.
//  GEN: pat_data_o=LFSR, pat_vld_o=1; on each accepted beat LFSR<=f(LFSR), tx_cnt--; last beat -> DRAIN.
//  MISR: in GEN/DRAIN on dut_vld_i: MISR<=f(MISR) ^ zext(dut_data_i); rx_cnt++ (saturates).
//  DUT beats outside GEN/DRAIN ignored (no MISR update).
//  DRAIN: rx_cnt==count -> CHECK; idle counter resets on each dut_vld_i;
//   reaching DRAIN_TMO idle cycles -> timeout flag set, -> CHECK.
//  CHECK (1 cyc): pass<=(MISR==golden_i) & ~timeout; -> DONE.
//  DONE: done_o=1, holds pass/timeout/signature until start_i or abort_i.
//  abort_i has priority over start_i and all transitions; -> IDLE, done_o=0, pat_vld_o=0 next cycle.
//  Same-cycle dut_vld_i and GEN->DRAIN transition: beat counted.
//  rst_n asserted mid-run: immediate return to reset values.
//  Latency: first pat_vld_o 2 cycles after start_i.
// CONFIGURATION
//  BIST_STALL_EN defined: adds input pat_rdy_i (1 bit); GEN beat accepted only when pat_vld_o & pat_rdy_i;
//   pat_data_o/pat_vld_o held stable while stalled; DRAIN timeout frozen while pat_rdy_i low.
//  Not defined: port absent, every GEN cycle is an accepted beat (count patterns in count cycles).
// TESTING
//  Reset: rst_n low mid-GEN -> all outputs 0, busy_o=0 next cycle.
//  seed=1,count=3 -> pat_data_o 0x000001,0xE10000,0x708000 on 3 consecutive cycles, then pat_vld_o=0.
//  MISR: dut beats 0x05 then 0x00 -> signature_o 0x000005 then 0xE10002; golden=0xE10002 -> done_o=1,pass_o=1.
//  Wrong golden (0xE10003) same stream -> done_o=1, pass_o=0, timeout_o=0.
//  count=4, only 2 dut beats -> after 64 idle cycles done_o=1, timeout_o=1, pass_o=0.
//  count=0 -> no pat_vld_o, done_o=1, pass_o=(golden==0); abort_i mid-GEN -> IDLE, done_o=0; seed=0 behaves as seed=1.

Source files
------------

// File: rtl/pixel_bist_ctrl.sv
// Self-test controller: seeded LFSR pattern source, MISR compaction of pipeline output, golden compare.
// Optional macro BIST_STALL_EN adds pat_rdy_i backpressure on the pattern stream.
module pixel_bist_ctrl #(
   parameter int                DATA_W    = 24,
   parameter int                PX_OUT_W  = 8,
   parameter int                CNT_W     = 16,
   parameter logic [DATA_W-1:0] POLY      = 24'hE10000,
   parameter int                DRAIN_TMO = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [DATA_W-1:0]   cfg_seed_i,
   input  logic [CNT_W-1:0]    cfg_count_i,
   input  logic [DATA_W-1:0]   golden_i,
`ifdef BIST_STALL_EN
   input  logic                pat_rdy_i,
`endif
   output logic [DATA_W-1:0]   pat_data_o,
   output logic                pat_vld_o,
   input  logic [PX_OUT_W-1:0] dut_data_i,
   input  logic                dut_vld_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic                timeout_o,
   output logic [DATA_W-1:0]   signature_o
);

   localparam int TMO_W = $clog2(DRAIN_TMO + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_GEN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Galois step shared by LFSR and MISR
   function automatic logic [DATA_W-1:0] step_f(input logic [DATA_W-1:0] s);
      step_f = {1'b0, s[DATA_W-1:1]} ^ (s[0] ? POLY : {DATA_W{1'b0}});
   endfunction

   state_t              state_r;
   state_t              next_state_s;
   logic [DATA_W-1:0]   lfsr_r;
   logic [DATA_W-1:0]   misr_r;
   logic [DATA_W-1:0]   seed_r;
   logic [CNT_W-1:0]    count_r;
   logic [CNT_W-1:0]    tx_cnt_r;
   logic [CNT_W-1:0]    rx_cnt_r;
   logic [TMO_W-1:0]    idle_r;
   logic                pat_vld_r;
   logic                busy_r;
   logic                done_r;
   logic                pass_r;
   logic                timeout_r;
   logic                accept_s;
   logic                tmo_run_s;
   logic                tmo_hit_s;
   logic                start_ok_s;
   logic                misr_en_s;

`ifdef BIST_STALL_EN
   assign accept_s  = pat_vld_r & pat_rdy_i;
   assign tmo_run_s = pat_rdy_i;
`else
   assign accept_s  = pat_vld_r;
   assign tmo_run_s = 1'b1;
`endif

   assign start_ok_s = start_i & ~abort_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign misr_en_s  = dut_vld_i & ((state_r == ST_GEN) | (state_r == ST_DRAIN));

   // Next-state decode; abort overrides every transition
   always_comb begin
      next_state_s = state_r;
      tmo_hit_s    = 1'b0;
      if (abort_i) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_i) next_state_s = ST_LOAD;
               else         next_state_s = state_r;
            end
            ST_LOAD: begin
               if (count_r == {CNT_W{1'b0}}) next_state_s = ST_CHECK;
               else                          next_state_s = ST_GEN;
            end
            ST_GEN: begin
               if (accept_s && (tx_cnt_r == {{(CNT_W-1){1'b0}}, 1'b1})) next_state_s = ST_DRAIN;
               else                                                      next_state_s = ST_GEN;
            end
            ST_DRAIN: begin
               if (rx_cnt_r == count_r) begin
                  next_state_s = ST_CHECK;
               end else if (!dut_vld_i && tmo_run_s && (idle_r == TMO_W'(DRAIN_TMO - 1))) begin
                  next_state_s = ST_CHECK;
                  tmo_hit_s    = 1'b1;
               end else begin
                  next_state_s = ST_DRAIN;
               end
            end
            ST_CHECK: next_state_s = ST_DONE;
            default:  next_state_s = ST_IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= next_state_s;
   end

   // Pattern generator, MISR and beat counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r   <= {{(DATA_W-1){1'b0}}, 1'b1};
         misr_r   <= {DATA_W{1'b0}};
         seed_r   <= {DATA_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         tx_cnt_r <= {CNT_W{1'b0}};
         rx_cnt_r <= {CNT_W{1'b0}};
         idle_r   <= {TMO_W{1'b0}};
      end else begin
         if (start_ok_s) begin
            seed_r  <= cfg_seed_i;
            count_r <= cfg_count_i;
         end
         if (state_r == ST_LOAD) begin
            lfsr_r   <= (seed_r == {DATA_W{1'b0}}) ? {{(DATA_W-1){1'b0}}, 1'b1} : seed_r;
            tx_cnt_r <= count_r;
            rx_cnt_r <= {CNT_W{1'b0}};
            idle_r   <= {TMO_W{1'b0}};
         end else if ((state_r == ST_GEN) && accept_s) begin
            lfsr_r   <= step_f(lfsr_r);
            tx_cnt_r <= tx_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (start_ok_s) begin
            misr_r <= {DATA_W{1'b0}};
         end else if (misr_en_s) begin
            misr_r <= step_f(misr_r) ^ {{(DATA_W-PX_OUT_W){1'b0}}, dut_data_i};
            if (rx_cnt_r != {CNT_W{1'b1}}) rx_cnt_r <= rx_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         // Idle counter only runs in DRAIN; any pipeline beat restarts it
         if (state_r == ST_DRAIN) begin
            if (dut_vld_i)      idle_r <= {TMO_W{1'b0}};
            else if (tmo_run_s) idle_r <= idle_r + {{(TMO_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_vld_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         pat_vld_r <= (next_state_s == ST_GEN);
         busy_r    <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
         done_r    <= (next_state_s == ST_DONE);
         if (abort_i || start_ok_s) begin
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
         end else if (tmo_hit_s) begin
            timeout_r <= 1'b1;
         end else if (state_r == ST_CHECK) begin
            pass_r <= (misr_r == golden_i) & ~timeout_r;
         end
      end
   end

   assign pat_data_o  = lfsr_r & {DATA_W{pat_vld_r}};
   assign pat_vld_o   = pat_vld_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign pass_o      = pass_r;
   assign timeout_o   = timeout_r;
   assign signature_o = misr_r;

endmodule

// File: tb/tb_pixel_bist_ctrl.sv
// Directed self-checking bench for pixel_bist_ctrl (default build, no stall port).
module tb_pixel_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        abort_i;
   logic [23:0] cfg_seed_i;
   logic [15:0] cfg_count_i;
   logic [23:0] golden_i;
   logic [23:0] pat_data_o;
   logic        pat_vld_o;
   logic [7:0]  dut_data_i;
   logic        dut_vld_i;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic        timeout_o;
   logic [23:0] signature_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pixel_bist_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .cfg_seed_i(cfg_seed_i), .cfg_count_i(cfg_count_i), .golden_i(golden_i),
      .pat_data_o(pat_data_o), .pat_vld_o(pat_vld_o),
      .dut_data_i(dut_data_i), .dut_vld_i(dut_vld_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .timeout_o(timeout_o), .signature_o(signature_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_run(input logic [23:0] seed, input logic [15:0] cnt, input logic [23:0] gold);
      cfg_seed_i  = seed;
      cfg_count_i = cnt;
      golden_i    = gold;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, done_o}, 32'd1);
   endtask

   task automatic mbist_stream(input logic [23:0] gold);
      start_run(24'h000001, 16'd2, gold);
      tick();
      dut_vld_i  = 1'b1;
      dut_data_i = 8'h05;
      tick();
      chk("misr_beat1", {8'd0, signature_o}, 32'h000005);
      dut_data_i = 8'h00;
      tick();
      chk("misr_beat2", {8'd0, signature_o}, 32'hE10002);
      dut_vld_i  = 1'b0;
      wait_done("misr_done", 10);
   endtask

   initial begin
      logic saw_vld;
      int   n;
      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      cfg_seed_i = 24'd0; cfg_count_i = 16'd0; golden_i = 24'd0;
      dut_data_i = 8'd0; dut_vld_i = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_pass", {31'd0, pass_o}, 32'd0);
      chk("rst_tmo",  {31'd0, timeout_o}, 32'd0);
      chk("rst_vld",  {31'd0, pat_vld_o}, 32'd0);
      chk("rst_data", {8'd0, pat_data_o}, 32'd0);
      chk("rst_sig",  {8'd0, signature_o}, 32'd0);
      rst_n = 1'b1;
      tick();

      // seed=1,count=3 pattern sequence, then abort in DRAIN
      start_run(24'h000001, 16'd3, 24'h0);
      chk("load_busy", {31'd0, busy_o}, 32'd1);
      chk("load_vld",  {31'd0, pat_vld_o}, 32'd0);
      tick();
      chk("gen_vld0",  {31'd0, pat_vld_o}, 32'd1);
      chk("gen_pat0",  {8'd0, pat_data_o}, 32'h000001);
      tick();
      chk("gen_pat1",  {8'd0, pat_data_o}, 32'hE10000);
      tick();
      chk("gen_pat2",  {8'd0, pat_data_o}, 32'h708000);
      chk("gen_vld2",  {31'd0, pat_vld_o}, 32'd1);
      tick();
      chk("drain_vld", {31'd0, pat_vld_o}, 32'd0);
      chk("drain_busy", {31'd0, busy_o}, 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_drain_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_drain_done", {31'd0, done_o}, 32'd0);
      dut_vld_i = 1'b1; dut_data_i = 8'hAA;
      tick();
      dut_vld_i = 1'b0;
      chk("idle_beat_ignored", {8'd0, signature_o}, 32'h000000);

      // matching golden
      mbist_stream(24'hE10002);
      chk("pass_ok",  {31'd0, pass_o}, 32'd1);
      chk("pass_tmo", {31'd0, timeout_o}, 32'd0);
      chk("pass_busy", {31'd0, busy_o}, 32'd0);
      tick(); tick(); tick();
      chk("done_hold", {31'd0, done_o}, 32'd1);
      chk("sig_hold",  {8'd0, signature_o}, 32'hE10002);

      // wrong golden, restarted from DONE
      mbist_stream(24'hE10003);
      chk("bad_pass", {31'd0, pass_o}, 32'd0);
      chk("bad_tmo",  {31'd0, timeout_o}, 32'd0);

      // count=4 with only 2 beats: timeout after exactly 64 idle DRAIN cycles
      start_run(24'h000001, 16'd4, 24'hE10002);
      chk("restart_done_clr", {31'd0, done_o}, 32'd0);
      tick();
      dut_vld_i = 1'b1; dut_data_i = 8'h05;
      tick();
      dut_data_i = 8'h00;
      tick();
      dut_vld_i = 1'b0;
      n = 0;
      while (pat_vld_o && n < 10) begin
         tick();
         n++;
      end
      chk("tmo_gen_end", {31'd0, pat_vld_o}, 32'd0);
      repeat (64) tick();
      chk("tmo_not_early", {31'd0, done_o}, 32'd0);
      tick();
      chk("tmo_done", {31'd0, done_o}, 32'd1);
      chk("tmo_flag", {31'd0, timeout_o}, 32'd1);
      chk("tmo_pass", {31'd0, pass_o}, 32'd0);

      // count=0: no patterns, pass iff golden==0 on cleared MISR
      start_run(24'h000007, 16'd0, 24'h0);
      saw_vld = 1'b0;
      n = 0;
      while (!done_o && n < 10) begin
         if (pat_vld_o) saw_vld = 1'b1;
         tick();
         n++;
      end
      chk("cnt0_done", {31'd0, done_o}, 32'd1);
      chk("cnt0_novld", {31'd0, saw_vld}, 32'd0);
      chk("cnt0_pass", {31'd0, pass_o}, 32'd1);
      chk("cnt0_sig",  {8'd0, signature_o}, 32'd0);

      // abort mid-GEN
      start_run(24'h000001, 16'd10, 24'h0);
      chk("abort_start_done", {31'd0, done_o}, 32'd0);
      tick(); tick();
      chk("abort_pre_vld", {31'd0, pat_vld_o}, 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_gen_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_gen_vld",  {31'd0, pat_vld_o}, 32'd0);
      chk("abort_gen_done", {31'd0, done_o}, 32'd0);

      // seed=0 behaves as seed=1, then reset mid-GEN
      start_run(24'h000000, 16'd5, 24'h0);
      tick();
      chk("seed0_pat0", {8'd0, pat_data_o}, 32'h000001);
      tick();
      chk("seed0_pat1", {8'd0, pat_data_o}, 32'hE10000);
      dut_vld_i = 1'b1; dut_data_i = 8'h33;
      tick();
      dut_vld_i = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      chk("midrst_vld",  {31'd0, pat_vld_o}, 32'd0);
      chk("midrst_data", {8'd0, pat_data_o}, 32'd0);
      chk("midrst_sig",  {8'd0, signature_o}, 32'd0);
      chk("midrst_done", {31'd0, done_o}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
